// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: word-request bundle between the TX FIFO/command logic and
// the UART serialiser.
//
// Handshake: the master raises tx_start for one clk cycle with tx_data stable
// in that cycle. The serialiser accepts the word only when it is idle
// (tx_busy=0 in that cycle, or in the cycle where tx_done=1). A request
// presented while busy is dropped, not queued. tx_busy stays high from the
// accepting edge to the end of the frame. tx_done pulses high for one cycle
// as tx_busy falls.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (output tx_start, output tx_data, input tx_busy, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// A frame is a start bit, then DATA_BITS data bits sent LSB first, then an
// optional parity bit, then STOP_BITS stop bits. Each bit lasts OVERSAMPLE
// b_tick pulses.
// Optional feature: define UART_TX_PARITY_EN to compile in the parity state.
// The parity sense comes from PARITY_ODD.
// All outputs are registered. The FSM state is exported on dbg_state_o.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           b_tick,
  uart_tx_param_if.slave tx_if,
  output logic           uart_tx,
  output logic [2:0]     dbg_state_o
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  line_q, line_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic bit_end;

  // A bit ends on the tick that completes OVERSAMPLE ticks.
  assign bit_end = b_tick && (tick_q == TICK_LAST);

  // State and datapath registers. Reset forces the line high, even in mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      line_q   <= line_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic. The line value for each state is computed one edge
  // early, so uart_tx comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    line_d   = line_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // Ticks are counted only inside a frame. The tick on the accepting edge
    // is not counted, because the counter is cleared there.
    if (state_q != S_IDLE && b_tick) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        line_d = 1'b1;
        busy_d = 1'b0;
        if (tx_if.tx_start) begin
          shift_d  = tx_if.tx_data;
          tick_d   = '0;
          bit_d    = '0;
          line_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_if.tx_data) ^ (PARITY_ODD != 0);
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          line_d  = shift_q[0];
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            line_d  = parity_q;
            state_d = S_PARITY;
`else
            line_d  = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d  = bit_q + 1'b1;
            line_d = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          line_d  = 1'b1;
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            line_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        line_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign uart_tx       = line_q;
  assign tx_if.tx_busy = busy_q;
  assign tx_if.tx_done = done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for uart_tx_param.
// There are three instances. dut a is 8-bit with even parity. dut b is 7-bit
// with 2 stop bits. dut c is 8-bit with odd parity. Parity bits appear only
// when UART_TX_PARITY_EN is defined.
// b_tick pulses every 4 clocks and OVERSAMPLE is 16, so one bit lasts 64 clocks.
module tb_uart_tx_param;

  localparam int OVS = 16;
  localparam int FW  = 21;   // {len[4:0], line bits[15:0]}; bit 0 is the start bit

  logic clk, rst, b_tick;
  logic tx_a, tx_b, tx_c;
  logic [2:0] dbg_a, dbg_b, dbg_c;
  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;

  logic [FW-1:0] exp_q0[$];
  logic [FW-1:0] exp_q1[$];
  logic [FW-1:0] exp_q2[$];

  uart_tx_param_if #(.DATA_BITS(8)) if_a ();
  uart_tx_param_if #(.DATA_BITS(7)) if_b ();
  uart_tx_param_if #(.DATA_BITS(8)) if_c ();

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0), .OVERSAMPLE(OVS)) dut_a (
    .clk(clk), .rst(rst), .b_tick(b_tick), .tx_if(if_a), .uart_tx(tx_a), .dbg_state_o(dbg_a));
  uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0), .OVERSAMPLE(OVS)) dut_b (
    .clk(clk), .rst(rst), .b_tick(b_tick), .tx_if(if_b), .uart_tx(tx_b), .dbg_state_o(dbg_b));
  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1), .OVERSAMPLE(OVS)) dut_c (
    .clk(clk), .rst(rst), .b_tick(b_tick), .tx_if(if_c), .uart_tx(tx_c), .dbg_state_o(dbg_c));

  logic line_w [3];
  logic busy_w [3];
  logic done_w [3];
  assign line_w[0] = tx_a;  assign busy_w[0] = if_a.tx_busy;  assign done_w[0] = if_a.tx_done;
  assign line_w[1] = tx_b;  assign busy_w[1] = if_b.tx_busy;  assign done_w[1] = if_b.tx_done;
  assign line_w[2] = tx_c;  assign busy_w[2] = if_c.tx_busy;  assign done_w[2] = if_c.tx_done;

  // ---------------- clock / reset / tick ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    b_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_cnt++;
      b_tick = (tick_cnt % 4 == 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h @%0t", name, id, act, req, $time);
    end
  endtask

  // Builds the expected line sequence: start 0, data bits LSB first,
  // [parity], then stop bits.
  function automatic logic [FW-1:0] make_frame(input logic [8:0] d, input int nb, input int ns,
                                               input bit odd);
    logic [15:0] bits;
    int len;
`ifdef UART_TX_PARITY_EN
    logic p;
    p = odd;
`endif
    bits = '0;
    len  = 1;
    for (int i = 0; i < nb; i++) begin
      bits[len] = d[i];
`ifdef UART_TX_PARITY_EN
      p = p ^ d[i];
`endif
      len++;
    end
`ifdef UART_TX_PARITY_EN
    bits[len] = p;
    len++;
`endif
    for (int i = 0; i < ns; i++) begin
      bits[len] = 1'b1;
      len++;
    end
    if (odd && 1'b0) len = 0;  // odd only matters when parity is compiled in
    return {5'(len), bits};
  endfunction

  function automatic bit pop_exp(input int id, output logic [FW-1:0] fr);
    fr = '0;
    case (id)
      0: if (exp_q0.size() > 0) begin fr = exp_q0.pop_front(); return 1'b1; end
      1: if (exp_q1.size() > 0) begin fr = exp_q1.pop_front(); return 1'b1; end
      default: if (exp_q2.size() > 0) begin fr = exp_q2.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  task automatic push_exp(input int id, input logic [8:0] d);
    case (id)
      0: exp_q0.push_back(make_frame(d, 8, 1, 1'b0));
      1: exp_q1.push_back(make_frame(d, 7, 2, 1'b0));
      default: exp_q2.push_back(make_frame(d, 8, 1, 1'b1));
    endcase
  endtask

  task automatic drive(input int id, input logic s, input logic [8:0] d);
    case (id)
      0: begin if_a.tx_start = s; if_a.tx_data = d[7:0]; end
      1: begin if_b.tx_start = s; if_b.tx_data = d[6:0]; end
      default: begin if_c.tx_start = s; if_c.tx_data = d[7:0]; end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // The request is driven at a negedge and accepted on the following posedge.
  // When align=1, the accepting edge also carries a b_tick. When now=1, the
  // request is driven at the current negedge without waiting for the next one.
  // After acceptance tx_data is inverted; the frame must not follow the change.
  task automatic send(input int id, input logic [8:0] d, input bit push, input bit align, input bit now);
    if (!now) @(negedge clk);
    if (align) begin
      for (int k = 0; k < 8 && b_tick !== 1'b1; k++) @(negedge clk);
    end
    if (push) push_exp(id, d);
    drive(id, 1'b1, d);
    @(negedge clk);
    drive(id, 1'b0, ~d);
  endtask

  task automatic wait_done(input int id, input int budget);
    int k;
    k = 0;
    while (done_w[id] !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_w[id] !== 1'b1) check("done_timeout", id, 32'd0, 32'd1);
  endtask

  // ---------------- monitor ----------------
  // Detects a start bit, pops the expected frame and follows it using the
  // bench's own b_tick count. Each bit must hold its value, with busy=1 and
  // done=0, for exactly OVS ticks. It then checks the frame-end edge and that
  // tx_done lasts a single cycle.
  task automatic run_mon(input int id);
    logic [FW-1:0] fr;
    logic [15:0] bits;
    int len, b, ticks;
    bit ok, aborted, was_end;
    was_end = 1'b0;
    forever begin
      @(negedge clk);
      if (was_end) begin
        check("done_single_pulse", id, 32'(done_w[id]), 32'd0);
        was_end = 1'b0;
      end
      if (!rst && line_w[id] === 1'b0) begin
        if (!pop_exp(id, fr)) begin
          check("unexpected_frame", id, 32'd1, 32'd0);
          for (int k = 0; k < 2000 && busy_w[id] !== 1'b0; k++) @(negedge clk);
          continue;
        end
        len = int'(fr[20:16]);
        bits = fr[15:0];
        b = 0; ticks = 0; ok = 1'b1; aborted = 1'b0;
        while (b < len) begin
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (line_w[id] !== bits[b] || busy_w[id] !== 1'b1 || done_w[id] !== 1'b0) ok = 1'b0;
          if (b_tick) ticks++;
          if (ticks == OVS) begin
            check($sformatf("frame_bit%0d_val%0d", b, bits[b]), id, 32'(ok), 32'd1);
            b++;
            ticks = 0;
            ok = 1'b1;
          end
          @(negedge clk);
        end
        if (aborted) begin
          @(negedge clk);
          check("rst_line", id, 32'(line_w[id]), 32'd1);
          check("rst_busy", id, 32'(busy_w[id]), 32'd0);
          check("rst_done", id, 32'(done_w[id]), 32'd0);
        end else begin
          check("end_done", id, 32'(done_w[id]), 32'd1);
          check("end_busy", id, 32'(busy_w[id]), 32'd0);
          check("end_line", id, 32'(line_w[id]), 32'd1);
          was_end = 1'b1;
        end
      end
    end
  endtask

  initial run_mon(0);
  initial run_mon(1);
  initial run_mon(2);

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 9'h0);
    drive(1, 1'b0, 9'h0);
    drive(2, 1'b0, 9'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_line_a", 0, 32'(tx_a), 32'd1);
    check("reset_busy_a", 0, 32'(if_a.tx_busy), 32'd0);
    check("reset_done_a", 0, 32'(if_a.tx_done), 32'd0);
    check("reset_state_a", 0, 32'(dbg_a), 32'd0);
    check("reset_line_b", 1, 32'(tx_b), 32'd1);
    check("reset_line_c", 2, 32'(tx_c), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1/8E1 'A'. The request coincides with a b_tick.
    send(0, 9'h041, 1'b1, 1'b1, 1'b0);
    wait_done(0, 1000);

    // 'A' with odd parity (plain 8N1 when parity is not compiled in).
    send(2, 9'h041, 1'b1, 1'b0, 1'b0);
    wait_done(2, 1000);

    // 7 data bits, 2 stop bits, 7'h55.
    send(1, 9'h055, 1'b1, 1'b0, 1'b0);
    wait_done(1, 1000);

    // 8'h3C frame. A mid-frame 8'hFF request must be ignored.
    // 8'hA5 is then issued in the tx_done cycle.
    send(0, 9'h03C, 1'b1, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    send(0, 9'h0FF, 1'b0, 1'b0, 1'b0);
    check("busy_at_ignored_req", 0, 32'(if_a.tx_busy), 32'd1);
    wait_done(0, 1000);
    send(0, 9'h0A5, 1'b1, 1'b0, 1'b1);
    wait_done(0, 1000);

    // Reset during data bit 3.
    repeat (4) @(negedge clk);
    send(0, 9'h041, 1'b1, 1'b0, 1'b0);
    repeat (280) @(negedge clk);
    check("state_before_rst", 0, 32'(dbg_a), 32'd2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_state_a", 0, 32'(dbg_a), 32'd0);
    check("rst_no_done", 0, 32'(if_a.tx_done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_no_done", 0, 32'(if_a.tx_done), 32'd0);

    // A fresh frame after reset.
    send(0, 9'h041, 1'b1, 1'b0, 1'b0);
    wait_done(0, 1000);

    repeat (20) @(negedge clk);
    check("exp_q0_empty", 0, 32'(exp_q0.size()), 32'd0);
    check("exp_q1_empty", 1, 32'(exp_q1.size()), 32'd0);
    check("exp_q2_empty", 2, 32'(exp_q2.size()), 32'd0);
    check("idle_line_a", 0, 32'(tx_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter: the next-generation serialiser for the UART path, with configurable data width, stop-bit count and optional parity. It frames one parallel word per `tx_start` request onto `uart_tx`, timed by the shared oversampling baud-tick pulse `b_tick` from the baud generator. It sits between the TX FIFO/command logic and the board pin.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal range 5–9.
- `STOP_BITS`, 1, stop bits per frame; 1 or 2.
- `PARITY_ODD`, 0, parity sense: 0 even, 1 odd. Used only with `UART_TX_PARITY_EN`.
- `OVERSAMPLE`, 16, `b_tick` pulses per bit; minimum 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_start`  in  1  one-cycle request; sampled only in IDLE.
- `b_tick`  in  1  one-`clk`-wide pulse at `OVERSAMPLE`× baud.
- `tx_data`  in  DATA_BITS  word to send; sampled on the accepting edge.
- `tx_busy`  out  1  high from the accepting edge until frame end.
- `tx_done`  out  1  one-cycle pulse at frame end.
- `uart_tx`  out  1  serial line; idles high.

## Operation
- State machine: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE:
  - `uart_tx`=1.
  - `tx_start`=1 on an edge latches `tx_data` into a shift register, clears the tick and bit counters, enters START, drives `uart_tx`=0 and sets `tx_busy`=1.
- START: line 0 for one bit time, then DATA.
- DATA:
  - Bits go out LSB first.
  - Each bit lasts one bit time, and the shift register shifts right at each bit end.
  - After `DATA_BITS` bits, go to PARITY (macro defined) or STOP.
- PARITY: line = XOR of the latched word, inverted when `PARITY_ODD`=1; held one bit time.
- STOP:
  - Line 1 for `STOP_BITS` bit times.
  - At the end, return to IDLE, pulse `tx_done` and clear `tx_busy`, all on the same edge.
- Bit time: a bit ends on the edge where `b_tick`=1 and the tick counter = `OVERSAMPLE`-1. The counter then wraps to 0.
  - The tick counter is ⌈log2 OVERSAMPLE⌉ bits wide.
  - The bit counter is ⌈log2 (DATA_BITS+1)⌉ bits wide.
- `tx_start` while `tx_busy`=1 is ignored; no queuing.
- `tx_data` changes after acceptance have no effect on the frame in flight.
- All outputs are registered.

## Timing
- Reset values: `uart_tx`=1, `tx_busy`=0, `tx_done`=0, state IDLE, counters 0. This holds even mid-frame, so the line returns high on the edge after `rst` is sampled high.
- Start latency: `uart_tx` falls and `tx_busy` rises on the same edge that samples `tx_start`.
- Start bit length: ticks are counted from the first `b_tick` after acceptance, so the start bit spans the partial tick interval plus `OVERSAMPLE` ticks. Every later bit is exactly `OVERSAMPLE` ticks.
- Frame length: 1 + `DATA_BITS` + P + `STOP_BITS` bit times, where P=1 with parity compiled in and 0 without.
- `tx_done`: high exactly one `clk` cycle, coincident with `tx_busy` falling.
- Back-to-back: `tx_start` asserted in the cycle `tx_done`=1 is accepted, because the state is already IDLE. The next start bit begins on that edge with no idle gap.
- `b_tick` and `tx_start` on the same edge in IDLE: the request is accepted, and that tick is not counted.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state and parity generator are compiled in.
  - Frames carry one parity bit per `PARITY_ODD`.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state exists; DATA goes straight to STOP.
  - `PARITY_ODD` is ignored.

## Test plan
Bench settings: `b_tick` every 4 `clk` cycles, `OVERSAMPLE`=16, so one bit = 64 clocks.
- 8N1 (macro off), `tx_data`=8'h41, `tx_start` for 1 cycle:
  - line sequence 0,1,0,0,0,0,0,1,0,1, each bit 64 clocks after the start bit;
  - `tx_done` is a single pulse.
- 8E1 (macro on, `PARITY_ODD`=0), 8'h41: parity bit 0. With `PARITY_ODD`=1: parity bit 1. Frame is 11 bits.
- `DATA_BITS`=7, `STOP_BITS`=2, 7'h55:
  - data sequence 1,0,1,0,1,0,1, then 128 clocks high;
  - `tx_busy` spans the whole frame.
- `tx_start` pulsed mid-frame with 8'hFF: ignored; the frame in flight is unchanged and no second frame is sent.
- 8'hA5 issued in the `tx_done` cycle of a prior 8'h3C frame: the second start bit begins on that edge and both frames decode correctly.
- `rst` asserted during DATA bit 3: `uart_tx`=1 and `tx_busy`=0 next edge, no `tx_done`; a fresh 8'h41 afterwards transmits correctly.
